// File: rtl/id_ex_stage_pkg.sv
// Shared types and constants for the ID/EX pipeline slice.
// Purely declarative: no logic, no latency.
// Control-bundle bit positions live here so decode and EX agree on layout.
package rv_pipe_pkg;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;
    localparam int CTRL_W = 16;

    // Decoded control bundle bit layout
    localparam int CTRL_REGWRITE  = 0;
    localparam int CTRL_MEMREAD   = 1;
    localparam int CTRL_MEMWRITE  = 2;
    localparam int CTRL_BRANCH    = 3;
    localparam int CTRL_ALUSRC    = 4;
    localparam int CTRL_ALUOP_LSB = 5;
    localparam int CTRL_ALUOP_MSB = 8;

    typedef logic [XLEN-1:0]   xlen_t;
    typedef logic [REG_AW-1:0] reg_idx_t;
    typedef logic [CTRL_W-1:0] ctrl_t;

    // A bubble carries no side effects: no write, no memory access, no branch
    localparam ctrl_t CTRL_NOP = '0;

    // Contents of the ID/EX pipeline register
    typedef struct packed {
        xlen_t       pc;
        logic [31:0] instr;
        xlen_t       imm;
        reg_idx_t    rs1;
        reg_idx_t    rs2;
        reg_idx_t    rd;
        ctrl_t       ctrl;
        xlen_t       op1;
        xlen_t       op2;
    } id_ex_t;

    // True when the WB write lands on register rs (x0 is never written)
    function automatic logic wb_hits(input logic we, input reg_idx_t wb_rd, input reg_idx_t rs);
        return we && (wb_rd != '0) && (wb_rd == rs);
    endfunction

endpackage

// File: rtl/id_ex_stage_if.sv
// Bundle of ID-side inputs, WB write-back, and EX-side outputs of the ID/EX stage.
// No logic, no latency.
// slave = the stage itself; master = whoever drives ID/WB and consumes EX.
interface id_ex_stage_if;
    import rv_pipe_pkg::*;

    // ID side
    logic        id_valid;
    xlen_t       id_pc;
    logic [31:0] id_instr;
    reg_idx_t    id_rs1;
    reg_idx_t    id_rs2;
    reg_idx_t    id_rd;
    logic        id_use_rs1;
    logic        id_use_rs2;
    ctrl_t       id_ctrl;
    xlen_t       id_imm;
    logic        id_stall;

    // Register file read data and WB write port
    xlen_t       rf_rdata1;
    xlen_t       rf_rdata2;
    logic        wb_RegWrite;
    reg_idx_t    wb_rd;
    xlen_t       wb_wdata;

    // EX side
    logic        ex_ready;
    logic        flush;
    logic        ex_valid;
    xlen_t       ex_pc;
    logic [31:0] ex_instr;
    xlen_t       ex_imm;
    reg_idx_t    ex_rs1;
    reg_idx_t    ex_rs2;
    reg_idx_t    ex_rd;
    ctrl_t       ex_ctrl;
    xlen_t       ex_op1;
    xlen_t       ex_op2;

    modport slave (
        input  id_valid, id_pc, id_instr, id_rs1, id_rs2, id_rd,
               id_use_rs1, id_use_rs2, id_ctrl, id_imm,
               rf_rdata1, rf_rdata2, wb_RegWrite, wb_rd, wb_wdata,
               ex_ready, flush,
        output id_stall, ex_valid, ex_pc, ex_instr, ex_imm,
               ex_rs1, ex_rs2, ex_rd, ex_ctrl, ex_op1, ex_op2
    );

    modport master (
        output id_valid, id_pc, id_instr, id_rs1, id_rs2, id_rd,
               id_use_rs1, id_use_rs2, id_ctrl, id_imm,
               rf_rdata1, rf_rdata2, wb_RegWrite, wb_rd, wb_wdata,
               ex_ready, flush,
        input  id_stall, ex_valid, ex_pc, ex_instr, ex_imm,
               ex_rs1, ex_rs2, ex_rd, ex_ctrl, ex_op1, ex_op2
    );

endinterface

// File: rtl/id_ex_stage_bypass.sv
// WB-to-ID write-through operand select; x0 always reads as zero.
// Combinational, zero latency.
// No flow control.
module rf_bypass_mux
    import rv_pipe_pkg::*;
(
    input  reg_idx_t i_rs,
    input  xlen_t    i_rf_rdata,
    input  logic     i_wb_regwrite,
    input  reg_idx_t i_wb_rd,
    input  xlen_t    i_wb_wdata,
    output xlen_t    o_op
);

    // x0 first, then the in-flight WB write, then the stored register value
    always_comb begin
        o_op = i_rf_rdata;
        if (i_rs == '0)
            o_op = '0;
        else if (wb_hits(i_wb_regwrite, i_wb_rd, i_rs))
            o_op = i_wb_wdata;
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with WB bypass, load-use bubble insertion and flush.
// Latency: one cycle ID -> EX; a load-use pair costs exactly one bubble.
// Holds when ex_valid && !ex_ready (id_stall asserted); flush overrides hold.
module id_ex_stage
    import rv_pipe_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    id_ex_stage_if.slave  bus
);

    id_ex_t r_ex;
    logic   r_ex_valid;

    xlen_t  w_op1;
    xlen_t  w_op2;
    xlen_t  w_hold_op1;
    xlen_t  w_hold_op2;
    logic   w_advance;
    logic   w_hazard;
    logic   w_use_hit;

    // Operands for the instruction currently in ID
    rf_bypass_mux u_byp_op1 (
        .i_rs          (bus.id_rs1),
        .i_rf_rdata    (bus.rf_rdata1),
        .i_wb_regwrite (bus.wb_RegWrite),
        .i_wb_rd       (bus.wb_rd),
        .i_wb_wdata    (bus.wb_wdata),
        .o_op          (w_op1)
    );

    rf_bypass_mux u_byp_op2 (
        .i_rs          (bus.id_rs2),
        .i_rf_rdata    (bus.rf_rdata2),
        .i_wb_regwrite (bus.wb_RegWrite),
        .i_wb_rd       (bus.wb_rd),
        .i_wb_wdata    (bus.wb_wdata),
        .o_op          (w_op2)
    );

    // Same select applied to the held operands, so a WB retiring while EX is
    // stalled refreshes the latched value instead of leaving it stale
    rf_bypass_mux u_hold_op1 (
        .i_rs          (r_ex.rs1),
        .i_rf_rdata    (r_ex.op1),
        .i_wb_regwrite (bus.wb_RegWrite),
        .i_wb_rd       (bus.wb_rd),
        .i_wb_wdata    (bus.wb_wdata),
        .o_op          (w_hold_op1)
    );

    rf_bypass_mux u_hold_op2 (
        .i_rs          (r_ex.rs2),
        .i_rf_rdata    (r_ex.op2),
        .i_wb_regwrite (bus.wb_RegWrite),
        .i_wb_rd       (bus.wb_rd),
        .i_wb_wdata    (bus.wb_wdata),
        .o_op          (w_hold_op2)
    );

    assign w_advance = !r_ex_valid || bus.ex_ready;

    // Only operands the ID instruction really reads can create a load-use hazard
    assign w_use_hit = (bus.id_use_rs1 && (bus.id_rs1 == r_ex.rd)) ||
                       (bus.id_use_rs2 && (bus.id_rs2 == r_ex.rd));

    assign w_hazard  = r_ex_valid && r_ex.ctrl[CTRL_MEMREAD] && (r_ex.rd != '0) && w_use_hit;

    assign bus.id_stall = bus.id_valid && !bus.flush && (!w_advance || w_hazard);

    // ID/EX register: flush > hold > bubble > load > drain
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ex_valid <= 1'b0;
            r_ex       <= '0;
            r_ex.ctrl  <= CTRL_NOP;
        end else if (bus.flush) begin
            r_ex_valid <= 1'b0;
            r_ex.ctrl  <= CTRL_NOP;
        end else if (!w_advance) begin
            r_ex.op1   <= w_hold_op1;
            r_ex.op2   <= w_hold_op2;
        end else if (w_hazard) begin
            r_ex_valid <= 1'b0;
            r_ex.ctrl  <= CTRL_NOP;
        end else if (bus.id_valid) begin
            r_ex_valid <= 1'b1;
            r_ex.pc    <= bus.id_pc;
            r_ex.instr <= bus.id_instr;
            r_ex.imm   <= bus.id_imm;
            r_ex.rs1   <= bus.id_rs1;
            r_ex.rs2   <= bus.id_rs2;
            r_ex.rd    <= bus.id_rd;
            r_ex.ctrl  <= bus.id_ctrl;
            r_ex.op1   <= w_op1;
            r_ex.op2   <= w_op2;
        end else begin
            r_ex_valid <= 1'b0;
            r_ex.ctrl  <= CTRL_NOP;
        end
    end

    assign bus.ex_valid = r_ex_valid;
    assign bus.ex_pc    = r_ex.pc;
    assign bus.ex_instr = r_ex.instr;
    assign bus.ex_imm   = r_ex.imm;
    assign bus.ex_rs1   = r_ex.rs1;
    assign bus.ex_rs2   = r_ex.rs2;
    assign bus.ex_rd    = r_ex.rd;
    assign bus.ex_ctrl  = r_ex.ctrl;
    assign bus.ex_op1   = r_ex.op1;
    assign bus.ex_op2   = r_ex.op2;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed scenarios followed by a randomized stream, all checked against an
// architectural model: EX must see each source register's committed value.
module tb_id_ex_stage;
    import rv_pipe_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    id_ex_stage_if bus();

    id_ex_stage dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Architectural register file as seen by software; index 0 holds junk to
    // prove the stage forces x0 to zero regardless of what the array returns
    xlen_t m_rf [32];

    typedef struct {
        logic        v;
        xlen_t       pc;
        logic [31:0] instr;
        xlen_t       imm;
        reg_idx_t    rs1;
        reg_idx_t    rs2;
        reg_idx_t    rd;
        ctrl_t       ctrl;
    } slot_t;

    slot_t m_slot;
    logic  m_last_stall;

    localparam ctrl_t C_ALU  = ctrl_t'(1 << CTRL_REGWRITE);
    localparam ctrl_t C_LOAD = ctrl_t'((1 << CTRL_REGWRITE) | (1 << CTRL_MEMREAD));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic xlen_t arch(input reg_idx_t r);
        return (r == '0) ? '0 : m_rf[r];
    endfunction

    // Instruction in EX is a load whose result the ID instruction needs
    function automatic logic m_hazard();
        return m_slot.v && m_slot.ctrl[CTRL_MEMREAD] && (m_slot.rd != '0) &&
               ((bus.id_use_rs1 && bus.id_rs1 == m_slot.rd) ||
                (bus.id_use_rs2 && bus.id_rs2 == m_slot.rd));
    endfunction

    function automatic logic m_stall();
        return bus.id_valid && !bus.flush && ((m_slot.v && !bus.ex_ready) || m_hazard());
    endfunction

    task automatic set_id(input logic vld, input xlen_t pc, input int rs1, input int rs2,
                          input int rd, input logic u1, input logic u2, input ctrl_t ctrl);
        bus.id_valid   = vld;
        bus.id_pc      = pc;
        bus.id_instr   = $urandom;
        bus.id_imm     = $urandom;
        bus.id_rs1     = reg_idx_t'(rs1);
        bus.id_rs2     = reg_idx_t'(rs2);
        bus.id_rd      = reg_idx_t'(rd);
        bus.id_use_rs1 = u1;
        bus.id_use_rs2 = u2;
        bus.id_ctrl    = ctrl;
    endtask

    task automatic set_wb(input logic we, input int rd, input xlen_t data);
        bus.wb_RegWrite = we;
        bus.wb_rd       = reg_idx_t'(rd);
        bus.wb_wdata    = data;
    endtask

    // One clock: check everything at the falling edge, advance the model,
    // then return 1 time unit after the rising edge
    task automatic step();
        slot_t nxt;
        bus.rf_rdata1 = m_rf[bus.id_rs1];
        bus.rf_rdata2 = m_rf[bus.id_rs2];
        @(negedge clk);
        chk("id_stall", 64'(bus.id_stall), 64'(m_stall()));
        chk("ex_valid", 64'(bus.ex_valid), 64'(m_slot.v));
        if (m_slot.v) begin
            chk("ex_pc",    64'(bus.ex_pc),    64'(m_slot.pc));
            chk("ex_instr", 64'(bus.ex_instr), 64'(m_slot.instr));
            chk("ex_imm",   64'(bus.ex_imm),   64'(m_slot.imm));
            chk("ex_rs1",   64'(bus.ex_rs1),   64'(m_slot.rs1));
            chk("ex_rs2",   64'(bus.ex_rs2),   64'(m_slot.rs2));
            chk("ex_rd",    64'(bus.ex_rd),    64'(m_slot.rd));
            chk("ex_ctrl",  64'(bus.ex_ctrl),  64'(m_slot.ctrl));
            chk("ex_op1",   64'(bus.ex_op1),   64'(arch(m_slot.rs1)));
            chk("ex_op2",   64'(bus.ex_op2),   64'(arch(m_slot.rs2)));
        end else begin
            chk("ex_ctrl_nop", 64'(bus.ex_ctrl), 64'(CTRL_NOP));
        end
        m_last_stall = m_stall();
        nxt = m_slot;
        if (bus.flush) begin
            nxt.v = 1'b0; nxt.ctrl = CTRL_NOP;
        end else if (m_slot.v && !bus.ex_ready) begin
            nxt = m_slot;
        end else if (m_hazard() || !bus.id_valid) begin
            nxt.v = 1'b0; nxt.ctrl = CTRL_NOP;
        end else begin
            nxt.v = 1'b1; nxt.pc = bus.id_pc; nxt.instr = bus.id_instr; nxt.imm = bus.id_imm;
            nxt.rs1 = bus.id_rs1; nxt.rs2 = bus.id_rs2; nxt.rd = bus.id_rd; nxt.ctrl = bus.id_ctrl;
        end
        if (bus.wb_RegWrite && bus.wb_rd != '0) m_rf[bus.wb_rd] = bus.wb_wdata;
        @(posedge clk);
        #1;
        m_slot = nxt;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) m_rf[i] = $urandom;
        m_rf[0] = 32'hBAD0_0000;
        m_rf[5] = 32'h1;
        m_rf[9] = 32'h55;
        m_slot = '{default: '0};
        m_last_stall = 1'b0;

        reset = 1'b1;
        set_id(1'b1, 32'h0, 1, 2, 3, 1'b1, 1'b1, C_ALU);
        set_wb(1'b0, 0, '0);
        bus.ex_ready = 1'b0;
        bus.flush = 1'b0;
        bus.rf_rdata1 = '0;
        bus.rf_rdata2 = '0;
        #2;
        chk("rst_ex_valid", 64'(bus.ex_valid), 64'd0);
        chk("rst_ex_ctrl",  64'(bus.ex_ctrl),  64'(CTRL_NOP));
        chk("rst_ex_pc",    64'(bus.ex_pc),    64'd0);
        chk("rst_ex_op1",   64'(bus.ex_op1),   64'd0);
        chk("rst_id_stall", 64'(bus.id_stall), 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        bus.ex_ready = 1'b1;

        // WB write-through into a same-cycle read of x5
        set_id(1'b1, 32'h100, 5, 0, 1, 1'b1, 1'b0, C_ALU);
        set_wb(1'b1, 5, 32'hDEADBEEF);
        step();
        chk("t1_op1",   64'(bus.ex_op1),   64'hDEADBEEF);
        chk("t1_valid", 64'(bus.ex_valid), 64'd1);

        // x0 never picks up a WB write to rd=0
        set_id(1'b1, 32'h104, 1, 0, 2, 1'b1, 1'b1, C_ALU);
        set_wb(1'b1, 0, 32'hFFFFFFFF);
        step();
        chk("t2_op2", 64'(bus.ex_op2), 64'd0);
        set_wb(1'b0, 0, '0);

        // Load-use on rs1: one stall cycle, one bubble, then entry
        set_id(1'b1, 32'h108, 2, 3, 7, 1'b1, 1'b0, C_LOAD);
        step();
        set_id(1'b1, 32'h10C, 7, 4, 8, 1'b1, 1'b0, C_ALU);
        #1;
        chk("t3_stall", 64'(bus.id_stall), 64'd1);
        step();
        chk("t3_bubble_valid", 64'(bus.ex_valid), 64'd0);
        chk("t3_bubble_ctrl",  64'(bus.ex_ctrl),  64'(CTRL_NOP));
        chk("t3_stall_after",  64'(bus.id_stall), 64'd0);
        step();
        chk("t3_enter_valid", 64'(bus.ex_valid), 64'd1);
        chk("t3_enter_pc",    64'(bus.ex_pc),    64'h10C);

        // Same producer, but the consumer does not read rs1: no stall
        set_id(1'b1, 32'h110, 2, 3, 7, 1'b1, 1'b0, C_LOAD);
        step();
        set_id(1'b1, 32'h114, 7, 7, 8, 1'b0, 1'b0, C_ALU);
        #1;
        chk("t4_stall", 64'(bus.id_stall), 64'd0);
        step();
        chk("t4_pc", 64'(bus.ex_pc), 64'h114);

        // EX stall for 3 cycles while WB retires x9 underneath the held operand
        set_id(1'b1, 32'h118, 1, 9, 10, 1'b1, 1'b1, C_ALU);
        step();
        chk("t5_op2_initial", 64'(bus.ex_op2), 64'h55);
        bus.ex_ready = 1'b0;
        set_id(1'b1, 32'h11C, 3, 4, 11, 1'b1, 1'b1, C_ALU);
        for (int c = 0; c < 3; c++) begin
            if (c == 1) set_wb(1'b1, 9, 32'h1234);
            else        set_wb(1'b0, 0, '0);
            #1;
            chk("t5_hold_stall", 64'(bus.id_stall), 64'd1);
            step();
        end
        set_wb(1'b0, 0, '0);
        chk("t5_op2_refreshed", 64'(bus.ex_op2), 64'h1234);
        chk("t5_pc_held",       64'(bus.ex_pc),  64'h118);
        bus.ex_ready = 1'b1;
        step();

        // Flush during a hold that is also a load-use hazard
        set_id(1'b1, 32'h120, 1, 2, 3, 1'b1, 1'b1, C_LOAD);
        step();
        bus.ex_ready = 1'b0;
        set_id(1'b1, 32'h124, 3, 4, 12, 1'b1, 1'b0, C_ALU);
        #1;
        chk("t6_stall_noflush", 64'(bus.id_stall), 64'd1);
        bus.flush = 1'b1;
        #1;
        chk("t6_stall_flush", 64'(bus.id_stall), 64'd0);
        step();
        chk("t6_valid", 64'(bus.ex_valid), 64'd0);
        bus.flush = 1'b0;
        bus.ex_ready = 1'b1;

        // Asynchronous reset between edges while EX holds a valid instruction
        set_id(1'b1, 32'h128, 1, 2, 13, 1'b1, 1'b1, C_ALU);
        bus.ex_ready = 1'b0;
        step();
        chk("t7_pre_valid", 64'(bus.ex_valid), 64'd1);
        #1 reset = 1'b1;
        #1;
        chk("t7_valid", 64'(bus.ex_valid), 64'd0);
        chk("t7_ctrl",  64'(bus.ex_ctrl),  64'(CTRL_NOP));
        chk("t7_pc",    64'(bus.ex_pc),    64'd0);
        #1 reset = 1'b0;
        m_slot = '{default: '0};
        bus.ex_ready = 1'b1;
        step();

        // Randomized stream: small register range to force collisions
        for (int n = 0; n < 800; n++) begin
            if (!m_last_stall)
                set_id(($urandom_range(0, 3) != 0), $urandom,
                       $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
                       1'($urandom), 1'($urandom),
                       ctrl_t'($urandom & 32'h1FF));
            bus.ex_ready = ($urandom_range(0, 9) < 7);
            bus.flush    = ($urandom_range(0, 15) == 0);
            set_wb(1'($urandom), $urandom_range(0, 7), $urandom);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
